// File: rtl/uart_cmd_sequencer.sv
// Turns single-byte axis commands from the UART into a settled accelerometer read and a
// checksummed 5-byte response frame; unknown bytes get a one-byte NAK.
module uart_cmd_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter logic [7:0]  HEADER        = 8'hA5,
  parameter logic [7:0]  NAK           = 8'h3F
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_data_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        tx_busy_i,
  input  logic [15:0] sample_data_i,
  output logic        tx_start_o,
  output logic [7:0]  tx_data_o,
  output logic [1:0]  dimension_o,
  output logic        busy_o,
  output logic        cmd_dropped_o,
  output logic        frame_done_o
);

  localparam int unsigned CntW    = 16;
  localparam int unsigned IdxW    = 3;
  localparam int unsigned ByteW   = 8;
  localparam int unsigned SampleW = 16;

  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(4);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SEND,
    WAIT_ACK,
    WAIT_IDLE
  } state_e;

  state_e              state_q;
  logic [ByteW-1:0]    cmd_q;
  logic                nak_q;
  logic [IdxW-1:0]     idx_q;
  logic [CntW-1:0]     cnt_q;
  logic [SampleW-1:0]  sample_q;
  logic                tx_start_q;
  logic [ByteW-1:0]    tx_data_q;
  logic [1:0]          dim_q;
  logic                busy_q;
  logic                drop_q;
  logic                done_q;

  logic                is_axis;
  logic                last_byte;
  logic [IdxW-1:0]     idx_next;
  logic [ByteW-1:0]    cur_byte;
  logic [ByteW-1:0]    next_byte;

  // Byte at a given frame position; a NAK frame is the NAK byte alone.
  function automatic logic [ByteW-1:0] frame_byte(
    input logic [IdxW-1:0]    idx,
    input logic               nak,
    input logic [ByteW-1:0]   cmd,
    input logic [SampleW-1:0] smp
  );
    logic [ByteW-1:0] b;
    b = HEADER ^ cmd ^ smp[7:0] ^ smp[15:8];
    if (nak) begin
      b = NAK;
    end else begin
      case (idx)
        3'd0:    b = HEADER;
        3'd1:    b = cmd;
        3'd2:    b = smp[7:0];
        3'd3:    b = smp[15:8];
        default: b = HEADER ^ cmd ^ smp[7:0] ^ smp[15:8];
      endcase
    end
    return b;
  endfunction

  always_comb begin
    is_axis   = (rx_data_i == 8'h78) || (rx_data_i == 8'h79) || (rx_data_i == 8'h7A);
    last_byte = nak_q ? (idx_q == '0) : (idx_q == LastIdx);
    idx_next  = idx_q + IdxW'(1);
    cur_byte  = frame_byte(idx_q, nak_q, cmd_q, sample_q);
    next_byte = frame_byte(idx_next, nak_q, cmd_q, sample_q);
  end

  // Whenever the next byte is ready and the transmitter is idle, it is launched on the
  // same edge rather than via a SEND cycle; SEND only holds bytes under back-pressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      nak_q      <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      sample_q   <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      dim_q      <= '0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      drop_q     <= rx_data_ready_i && (state_q != IDLE);
      done_q     <= 1'b0;

      case (state_q)
        IDLE: begin
          if (rx_data_ready_i) begin
            busy_q <= 1'b1;
            idx_q  <= '0;
            cnt_q  <= '0;
            cmd_q  <= rx_data_i;
            if (is_axis) begin
              nak_q   <= 1'b0;
              dim_q   <= rx_data_i[1:0];
              state_q <= SETTLE;
            end else begin
              nak_q <= 1'b1;
              if (!tx_busy_i) begin
                tx_start_q <= 1'b1;
                tx_data_q  <= NAK;
                state_q    <= WAIT_ACK;
              end else begin
                state_q <= SEND;
              end
            end
          end
        end

        SETTLE: begin
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == SettleLast) begin
            sample_q <= sample_data_i;
            if (!tx_busy_i) begin
              tx_start_q <= 1'b1;
              tx_data_q  <= HEADER;
              state_q    <= WAIT_ACK;
            end else begin
              state_q <= SEND;
            end
          end
        end

        SEND: begin
          if (!tx_busy_i) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= cur_byte;
            state_q    <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          if (tx_busy_i) begin
            state_q <= WAIT_IDLE;
          end
        end

        WAIT_IDLE: begin
          if (!tx_busy_i) begin
            if (last_byte) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q      <= idx_next;
              tx_start_q <= 1'b1;
              tx_data_q  <= next_byte;
              state_q    <= WAIT_ACK;
            end
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_start_o    = tx_start_q;
  assign tx_data_o     = tx_data_q;
  assign dimension_o   = dim_q;
  assign busy_o        = busy_q;
  assign cmd_dropped_o = drop_q;
  assign frame_done_o  = done_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer with a behavioural UART transmitter model.
module tb_uart_cmd_sequencer;

  localparam int TX_LEN = 6;

  logic        clk;
  logic        rst;
  logic        rx_data_ready;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic [15:0] sample_data;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [1:0]  dimension;
  logic        busy;
  logic        cmd_dropped;
  logic        frame_done;

  int          checks = 0;
  int          errors = 0;

  int          busy_cnt = 0;
  bit          force_busy = 1'b0;
  logic [7:0]  sent[$];
  int          start_cnt = 0;
  int          done_cnt = 0;
  int          drop_cnt = 0;
  int          viol_busy = 0;
  int          viol_back = 0;
  int          viol_data = 0;
  logic        prev_start = 1'b0;
  logic        stable_en = 1'b0;
  logic [7:0]  hold_byte = 8'h00;

  uart_cmd_sequencer #(
    .SETTLE_CYCLES(4),
    .HEADER(8'hA5),
    .NAK(8'h3F)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rx_data_ready_i(rx_data_ready),
    .rx_data_i      (rx_data),
    .tx_busy_i      (tx_busy),
    .sample_data_i  (sample_data),
    .tx_start_o     (tx_start),
    .tx_data_o      (tx_data),
    .dimension_o    (dimension),
    .busy_o         (busy),
    .cmd_dropped_o  (cmd_dropped),
    .frame_done_o   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tx_busy = (busy_cnt != 0) || force_busy;

  // Transmitter model: busy for TX_LEN cycles from the edge after tx_start; ignores rst.
  always @(posedge clk) begin
    if (tx_start) begin
      busy_cnt <= TX_LEN;
      sent.push_back(tx_data);
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Protocol monitor: pulse counts and tx_start / tx_data rule violations.
  always @(posedge clk) begin
    if (tx_start) start_cnt++;
    if (frame_done) done_cnt++;
    if (cmd_dropped) drop_cnt++;
    if (tx_start && tx_busy) viol_busy++;
    if (tx_start && prev_start) viol_back++;
    prev_start = tx_start;
    if (rst) begin
      stable_en = 1'b0;
    end else if (tx_start) begin
      stable_en = 1'b1;
      hold_byte = tx_data;
    end else if (stable_en && tx_busy && tx_data !== hold_byte) begin
      viol_data++;
    end
  end

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    rx_data_ready = 1'b1;
    rx_data       = b;
    @(negedge clk);
    rx_data_ready = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output logic busy_at);
    seen    = 1'b0;
    busy_at = 1'bx;
    for (int i = 0; i < 300; i++) begin
      if (frame_done) begin
        seen    = 1'b1;
        busy_at = busy;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b exp 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    checks++; if (dimension !== 2'd0) begin errors++; $display("FAIL reset_dimension got %0d exp 0", dimension); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (cmd_dropped !== 1'b0) begin errors++; $display("FAIL reset_cmd_dropped got %b exp 0", cmd_dropped); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_read;
    logic [7:0] exp[5] = '{8'hA5, 8'h79, 8'hC3, 8'hA5, 8'hBA};
    int s0, d0;
    bit seen;
    logic busy_at;
    bit early;
    sent.delete();
    s0 = start_cnt; d0 = done_cnt;
    sample_data = 16'hA5C3;
    send_cmd(8'h79);
    checks++; if (dimension !== 2'd1) begin errors++; $display("FAIL basic_dimension got %0d exp 1", dimension); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
    early = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (tx_start) early = 1'b1;
    end
    @(negedge clk);
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL basic_early_start got %b exp 0", early); end
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin
      errors++; $display("FAIL basic_first_start got start=%b data=%h exp start=1 data=a5", tx_start, tx_data);
    end
    wait_done(seen, busy_at);
    checks++; if (!seen) begin errors++; $display("FAIL basic_frame_done got timeout exp pulse"); end
    checks++; if (busy_at !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b exp 0", busy_at); end
    @(negedge clk);
    checks++; if (sent.size() != 5) begin errors++; $display("FAIL basic_byte_count got %0d exp 5", sent.size()); end
    else for (int i = 0; i < 5; i++) begin
      checks++; if (sent[i] !== exp[i]) begin errors++; $display("FAIL basic_byte%0d got %h exp %h", i, sent[i], exp[i]); end
    end
    checks++; if (start_cnt - s0 != 5) begin errors++; $display("FAIL basic_start_pulses got %0d exp 5", start_cnt - s0); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_pulses got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_bad_cmd;
    bit seen;
    logic busy_at;
    int s0;
    sent.delete();
    s0 = start_cnt;
    send_cmd(8'h41);
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h3F) begin
      errors++; $display("FAIL nak_start got start=%b data=%h exp start=1 data=3f", tx_start, tx_data);
    end
    checks++; if (dimension !== 2'd1) begin errors++; $display("FAIL nak_dimension got %0d exp 1", dimension); end
    wait_done(seen, busy_at);
    checks++; if (!seen) begin errors++; $display("FAIL nak_frame_done got timeout exp pulse"); end
    @(negedge clk);
    checks++; if (sent.size() != 1 || sent[0] !== 8'h3F) begin
      errors++; $display("FAIL nak_bytes got count=%0d first=%h exp count=1 first=3f", sent.size(), (sent.size() > 0) ? sent[0] : 8'hxx);
    end
    checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL nak_start_pulses got %0d exp 1", start_cnt - s0); end
  endtask

  task automatic test_drop_busy;
    logic [7:0] exp[5] = '{8'hA5, 8'h78, 8'hEF, 8'hBE, 8'h8C};
    int r0;
    bit seen;
    logic busy_at;
    sent.delete();
    r0 = drop_cnt;
    sample_data = 16'hBEEF;
    send_cmd(8'h78);
    for (int i = 0; i < 300 && sent.size() < 3; i++) @(negedge clk);
    checks++; if (sent.size() < 3) begin errors++; $display("FAIL drop_reach_byte2 got %0d bytes exp 3", sent.size()); end
    send_cmd(8'h7A);
    checks++; if (cmd_dropped !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b exp 1", cmd_dropped); end
    wait_done(seen, busy_at);
    checks++; if (!seen) begin errors++; $display("FAIL drop_frame_done got timeout exp pulse"); end
    @(negedge clk);
    checks++; if (sent.size() != 5) begin errors++; $display("FAIL drop_byte_count got %0d exp 5", sent.size()); end
    else for (int i = 0; i < 5; i++) begin
      checks++; if (sent[i] !== exp[i]) begin errors++; $display("FAIL drop_byte%0d got %h exp %h", i, sent[i], exp[i]); end
    end
    checks++; if (drop_cnt - r0 != 1) begin errors++; $display("FAIL drop_pulse_count got %0d exp 1", drop_cnt - r0); end
    checks++; if (dimension !== 2'd0) begin errors++; $display("FAIL drop_dimension got %0d exp 0", dimension); end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp[5] = '{8'hA5, 8'h78, 8'h02, 8'h01, 8'hDE};
    logic [7:0] held;
    bit bad_start, bad_data, seen;
    logic busy_at;
    sent.delete();
    sample_data = 16'h0102;
    force_busy = 1'b1;
    send_cmd(8'h78);
    held = tx_data;
    bad_start = 1'b0; bad_data = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (tx_start !== 1'b0) bad_start = 1'b1;
      if (tx_data !== held) bad_data = 1'b1;
    end
    checks++; if (bad_start) begin errors++; $display("FAIL bp_no_start got pulse exp none"); end
    checks++; if (bad_data) begin errors++; $display("FAIL bp_data_stable got change exp stable %h", held); end
    force_busy = 1'b0;
    @(negedge clk);
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin
      errors++; $display("FAIL bp_release_start got start=%b data=%h exp start=1 data=a5", tx_start, tx_data);
    end
    wait_done(seen, busy_at);
    checks++; if (!seen) begin errors++; $display("FAIL bp_frame_done got timeout exp pulse"); end
    @(negedge clk);
    checks++; if (sent.size() != 5) begin errors++; $display("FAIL bp_byte_count got %0d exp 5", sent.size()); end
    else for (int i = 0; i < 5; i++) begin
      checks++; if (sent[i] !== exp[i]) begin errors++; $display("FAIL bp_byte%0d got %h exp %h", i, sent[i], exp[i]); end
    end
  endtask

  task automatic test_latch_point;
    logic [7:0] exp[5] = '{8'hA5, 8'h78, 8'h34, 8'h12, 8'hFB};
    bit seen;
    logic busy_at;
    sent.delete();
    sample_data = 16'h1234;
    send_cmd(8'h78);
    repeat (4) @(negedge clk);
    sample_data = 16'h5678;
    wait_done(seen, busy_at);
    checks++; if (!seen) begin errors++; $display("FAIL latch_frame_done got timeout exp pulse"); end
    @(negedge clk);
    checks++; if (sent.size() != 5) begin errors++; $display("FAIL latch_byte_count got %0d exp 5", sent.size()); end
    else for (int i = 0; i < 5; i++) begin
      checks++; if (sent[i] !== exp[i]) begin errors++; $display("FAIL latch_byte%0d got %h exp %h", i, sent[i], exp[i]); end
    end
  endtask

  task automatic test_drop_at_frame_end;
    int s0, r0;
    s0 = start_cnt; r0 = drop_cnt;
    sent.delete();
    send_cmd(8'h41);
    for (int i = 0; i < 100 && sent.size() < 1; i++) @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 100 && tx_busy; i++) @(negedge clk);
    rx_data_ready = 1'b1;
    rx_data       = 8'h78;
    @(negedge clk);
    rx_data_ready = 1'b0;
    checks++; if (frame_done !== 1'b1 || cmd_dropped !== 1'b1) begin
      errors++; $display("FAIL end_drop got done=%b dropped=%b exp done=1 dropped=1", frame_done, cmd_dropped);
    end
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0 || start_cnt - s0 != 1) begin
      errors++; $display("FAIL end_drop_no_frame got busy=%b starts=%0d exp busy=0 starts=1", busy, start_cnt - s0);
    end
    checks++; if (dimension !== 2'd0 || drop_cnt - r0 != 1) begin
      errors++; $display("FAIL end_drop_state got dim=%0d drops=%0d exp dim=0 drops=1", dimension, drop_cnt - r0);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] exp[5] = '{8'hA5, 8'h7A, 8'hFF, 8'hFF, 8'hDF};
    int s0;
    bit seen;
    logic busy_at;
    sent.delete();
    sample_data = 16'h4321;
    send_cmd(8'h79);
    for (int i = 0; i < 300 && sent.size() < 2; i++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (tx_start !== 1'b0 || tx_data !== 8'h00 || dimension !== 2'd0) begin
      errors++; $display("FAIL rst_mid_outputs got start=%b data=%h dim=%0d exp 0 00 0", tx_start, tx_data, dimension);
    end
    checks++; if (busy !== 1'b0 || cmd_dropped !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flags got busy=%b drop=%b done=%b exp 0 0 0", busy, cmd_dropped, frame_done);
    end
    s0 = start_cnt;
    repeat (30) @(negedge clk);
    checks++; if (start_cnt != s0 || sent.size() != 2) begin
      errors++; $display("FAIL rst_mid_no_start got starts=%0d bytes=%0d exp 0 2", start_cnt - s0, sent.size());
    end
    sent.delete();
    sample_data = 16'hFFFF;
    send_cmd(8'h7A);
    checks++; if (dimension !== 2'd2) begin errors++; $display("FAIL rst_next_dimension got %0d exp 2", dimension); end
    wait_done(seen, busy_at);
    checks++; if (!seen) begin errors++; $display("FAIL rst_next_frame_done got timeout exp pulse"); end
    @(negedge clk);
    checks++; if (sent.size() != 5) begin errors++; $display("FAIL rst_next_byte_count got %0d exp 5", sent.size()); end
    else for (int i = 0; i < 5; i++) begin
      checks++; if (sent[i] !== exp[i]) begin errors++; $display("FAIL rst_next_byte%0d got %h exp %h", i, sent[i], exp[i]); end
    end
  endtask

  task automatic test_tx_protocol;
    checks++; if (viol_busy != 0) begin errors++; $display("FAIL proto_start_while_busy got %0d exp 0", viol_busy); end
    checks++; if (viol_back != 0) begin errors++; $display("FAIL proto_back_to_back_start got %0d exp 0", viol_back); end
    checks++; if (viol_data != 0) begin errors++; $display("FAIL proto_data_unstable got %0d exp 0", viol_data); end
  endtask

  initial begin
    rst           = 1'b1;
    rx_data_ready = 1'b0;
    rx_data       = 8'h00;
    sample_data   = 16'h0000;
    test_reset();
    test_basic_read();
    test_bad_cmd();
    test_drop_busy();
    test_backpressure();
    test_latch_point();
    test_drop_at_frame_end();
    test_reset_mid_frame();
    test_tx_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_cmd_sequencer.md
# uart_cmd_sequencer

Command/response sequencer between the UART receiver/transmitter pair and the accelerometer SPI reader on the DE0-Nano board. The UART receiver delivers single-byte axis commands ('x', 'y', 'z'). For each one, the block drives the axis select to the SPI reader, waits for the reading to settle and latches the 16-bit sample. It then sends a checksummed 5-byte frame through the UART transmitter, one byte per handshake. Unknown commands get a one-byte NAK. Commands that arrive while a frame is in progress are dropped and flagged.

## Interface
- SETTLE_CYCLES, 1000: clk cycles between axis change and sample latch. Legal range 1..65535; 16-bit counter.
- HEADER, 8'hA5: first byte of every response frame.
- NAK, 8'h3F: byte sent for an unrecognised command.

- clk  in  1  system clock (CLK_50 at top level); one clock domain.
- rst  in  1  synchronous, active-high reset.
- rx_data_ready  in  1  one-cycle pulse from async_receiver; rx_data valid in the same cycle.
- rx_data  in  8  received command byte.
- tx_busy  in  1  async_transmitter busy.
- sample_data  in  16  accelerometer reading for the selected axis, {high, low}. Already synchronised to clk upstream.
- tx_start  out  1  one-cycle start pulse to async_transmitter.
- tx_data  out  8  byte to transmit; stable from the tx_start cycle until tx_busy deasserts.
- dimension  out  2  axis select to spi_ee_config: 0=x, 1=y, 2=z.
- busy  out  1  high in every state except IDLE.
- cmd_dropped  out  1  one-cycle pulse when a command is discarded.
- frame_done  out  1  one-cycle pulse when the last byte of a frame (or the NAK) is finished.

## Operation
- Reset values: state IDLE, tx_start 0, tx_data 8'h00, dimension 0, busy 0, cmd_dropped 0, frame_done 0, byte index 0, settle counter 0, latched sample 0.
- States: IDLE, SETTLE, SEND, WAIT_ACK, WAIT_IDLE.
- IDLE + rx_data_ready, command 8'h78/79/7A:
  - register cmd;
  - dimension <= 0/1/2;
  - go to SETTLE with counter 0 and byte index 0.
- IDLE + rx_data_ready, any other byte: frame is the NAK byte alone; go to SEND. dimension is unchanged.
- SETTLE:
  - counter increments each cycle;
  - on the cycle counter == SETTLE_CYCLES-1, latch sample_data and go to SEND.
- Frame bytes, index 0..4:
  - 0: HEADER;
  - 1: cmd byte echo;
  - 2: sample[7:0];
  - 3: sample[15:8];
  - 4: XOR of bytes 0..3.
- SEND:
  - if tx_busy=0: pulse tx_start, drive tx_data with the current byte, go to WAIT_ACK;
  - if tx_busy=1: hold in SEND.
- WAIT_ACK: wait for tx_busy=1, then go to WAIT_IDLE. There is no timeout; the transmitter guarantees busy the cycle after start.
- WAIT_IDLE: on tx_busy=0:
  - if the last byte is done, pulse frame_done and go to IDLE;
  - otherwise increment the index and go to SEND.
- rx_data_ready in any non-IDLE state: command discarded, cmd_dropped pulses the next cycle. Current frame and dimension are unaffected.
- rx_data_ready in the same cycle as the final WAIT_IDLE→IDLE transition: dropped. IDLE only accepts a command on a cycle it is resident in IDLE.
- Synchronous rst mid-frame: all registers return to reset values at the next edge. A byte already in flight in the transmitter completes; no further bytes are sent.

## Timing
- Command captured at edge E (rx_data_ready sampled high):
  - dimension valid and busy=1 from E+1;
  - sample_data latched at edge E+SETTLE_CYCLES;
  - first tx_start high in cycle after E+SETTLE_CYCLES, if tx_busy=0.
- NAK: tx_start high in the cycle after E.
- Inter-byte gap: tx_start for byte n+1 is high in the cycle after tx_busy is first seen low in WAIT_IDLE.
- frame_done is high in the cycle after the last byte's tx_busy is seen low; busy is low in that same cycle.
- tx_start is never high on two consecutive cycles and never high while tx_busy=1.

## Test plan
- Basic read: SETTLE_CYCLES=4, sample_data=16'hA5C3, send 8'h79.
  - dimension=1 at E+1;
  - bytes A5, 79, C3, A5, BA in order;
  - exactly 5 tx_start pulses, then frame_done.
- Bad command: send 8'h41.
  - single byte 3F, tx_start at E+1;
  - dimension keeps its prior value.
- Drop while busy: send 8'h78, then 8'h7A during byte 2.
  - cmd_dropped pulses once;
  - frame completes with echo 78;
  - dimension stays 0.
- Back-pressure: hold tx_busy=1 for 50 cycles while in SEND.
  - tx_start stays 0;
  - it fires the cycle after tx_busy falls;
  - tx_data is stable throughout.
- Sample latch point: change sample_data from 16'h1234 to 16'h5678 one cycle after the latch edge.
  - frame carries 34, 12, checksum A5^78^34^12 = FB (for cmd 8'h78).
- Reset mid-frame: assert rst during WAIT_IDLE of byte 1.
  - all outputs at reset values next cycle;
  - no further tx_start;
  - next command produces a full, correct frame.
